// File: rtl/pc_block.sv
// ---------------------------------------------------------------------------
// pc_block
// Program counter register for the RISC-V fetch stage. Each enabled cycle the
// next address is chosen from a sequential increment, an immediate-computed
// branch/jump target, an ALU-computed target (JALR), or hold. The registered
// pc drives the instruction memory address directly.
//
// Optional build macro: PC_ALIGN_EN
//   When defined, targets loaded from imm_addr/alu_addr have bits [1:0]
//   cleared, and a registered pc_misalign output pulses for one cycle after
//   a load whose selected target had nonzero bits [1:0].
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, ACTIVE HIGH despite the _n suffix
//   pc_en        update enable (0 = hold)
//   pc_sel       next-pc source: 00 inc, 01 imm_addr, 10 alu_addr, 11 hold
//   imm_addr     immediate-computed target
//   alu_addr     ALU-computed target
//   pc           current program counter (registered)
//   pc_misalign  (PC_ALIGN_EN only) misaligned-target flag (registered)
// ---------------------------------------------------------------------------
module pc_block #(
    parameter int                 ADDR_W       = 11,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
    parameter int                 PC_INC       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_en,
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] imm_addr,
    input  logic [ADDR_W-1:0] alu_addr,
`ifdef PC_ALIGN_EN
    output logic              pc_misalign,
`endif
    output logic [ADDR_W-1:0] pc
);

    // Increment truncated to the pc width so the add wraps modulo 2^ADDR_W.
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    typedef enum logic [1:0] {
        SEL_INC  = 2'b00,
        SEL_IMM  = 2'b01,
        SEL_ALU  = 2'b10,
        SEL_HOLD = 2'b11
    } pc_sel_t;

    logic [ADDR_W-1:0] target;
    logic              load;

    always_comb begin
        target = (pc_sel == SEL_ALU) ? alu_addr : imm_addr;
        load   = pc_en && (pc_sel == SEL_IMM || pc_sel == SEL_ALU);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc <= RESET_VECTOR;
        end else if (pc_en) begin
            case (pc_sel_t'(pc_sel))
                SEL_INC:  pc <= pc + INC;
`ifdef PC_ALIGN_EN
                SEL_IMM,
                SEL_ALU:  pc <= {target[ADDR_W-1:2], 2'b00};
`else
                SEL_IMM,
                SEL_ALU:  pc <= target;
`endif
                default:  pc <= pc;
            endcase
        end
    end

`ifdef PC_ALIGN_EN
    // Flag reflects only the most recent cycle; it clears on any non-load.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc_misalign <= 1'b0;
        end else begin
            pc_misalign <= load && (target[1:0] != 2'b00);
        end
    end
`else
    logic unused_load;
    assign unused_load = load;
`endif

endmodule

// File: tb/tb_pc_block.sv
module tb_pc_block;

    localparam int ADDR_W = 11;
    localparam int MASK   = (1 << ADDR_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              pc_en;
    logic [1:0]        pc_sel;
    logic [ADDR_W-1:0] imm_addr;
    logic [ADDR_W-1:0] alu_addr;
    logic [ADDR_W-1:0] pc;
`ifdef PC_ALIGN_EN
    logic              pc_misalign;
`endif

    int vectors;
    int miscompares;

    pc_block #(.ADDR_W(ADDR_W), .RESET_VECTOR(11'h000), .PC_INC(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_en       (pc_en),
        .pc_sel      (pc_sel),
        .imm_addr    (imm_addr),
        .alu_addr    (alu_addr),
`ifdef PC_ALIGN_EN
        .pc_misalign (pc_misalign),
`endif
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              en;
        logic [1:0]        sel;
        logic [ADDR_W-1:0] imm;
        logic [ADDR_W-1:0] alu;
        logic [ADDR_W-1:0] exp_pc;
        logic              exp_mis;
    } vec_t;

    vec_t vecs[$];

    // Drive one cycle of inputs, let one posedge pass, then check just after it.
    task automatic apply(input logic rst, input logic en, input logic [1:0] sel,
                         input logic [ADDR_W-1:0] imm, input logic [ADDR_W-1:0] alu,
                         input logic [ADDR_W-1:0] exp_pc, input logic exp_mis,
                         input string name);
        rst_n    = rst;
        pc_en    = en;
        pc_sel   = sel;
        imm_addr = imm;
        alu_addr = alu;
        @(posedge clk);
        #1;
        vectors++;
        if (pc !== exp_pc) begin
            miscompares++;
            $display("FAIL %s pc: got 0x%03h expected 0x%03h", name, pc, exp_pc);
        end
`ifdef PC_ALIGN_EN
        if (pc_misalign !== exp_mis) begin
            miscompares++;
            $display("FAIL %s pc_misalign: got %b expected %b", name, pc_misalign, exp_mis);
        end
`else
        if (exp_mis) begin end
`endif
    endtask

    function automatic vec_t mk(logic rst, logic en, logic [1:0] sel,
                                logic [ADDR_W-1:0] imm, logic [ADDR_W-1:0] alu,
                                logic [ADDR_W-1:0] exp_pc, logic exp_mis);
        vec_t v;
        v.rst = rst; v.en = en; v.sel = sel; v.imm = imm; v.alu = alu;
        v.exp_pc = exp_pc; v.exp_mis = exp_mis;
        return v;
    endfunction

    initial begin
        int model_pc;
        logic r, e;
        logic [1:0] s;
        logic [ADDR_W-1:0] im, al;
        logic [ADDR_W-1:0] tgt;
        logic mis;
        logic align_on;

        vectors     = 0;
        miscompares = 0;
`ifdef PC_ALIGN_EN
        align_on = 1'b1;
`else
        align_on = 1'b0;
`endif

        rst_n = 1'b1; pc_en = 1'b0; pc_sel = 2'b00; imm_addr = '0; alu_addr = '0;
        @(negedge clk);

        // Directed table from the test plan.
        vecs.push_back(mk(1, 1, 2'b00, 11'h000, 11'h000, 11'h000, 0));
        vecs.push_back(mk(1, 1, 2'b00, 11'h000, 11'h000, 11'h000, 0));
        vecs.push_back(mk(1, 0, 2'b00, 11'h000, 11'h000, 11'h000, 0));
        vecs.push_back(mk(1, 0, 2'b00, 11'h000, 11'h000, 11'h000, 0));
        vecs.push_back(mk(0, 1, 2'b00, 11'h000, 11'h000, 11'h004, 0));
        vecs.push_back(mk(0, 1, 2'b00, 11'h000, 11'h000, 11'h008, 0));
        vecs.push_back(mk(0, 1, 2'b00, 11'h000, 11'h000, 11'h00C, 0));
        vecs.push_back(mk(0, 1, 2'b01, 11'h100, 11'h000, 11'h100, 0));
        vecs.push_back(mk(0, 1, 2'b00, 11'h000, 11'h000, 11'h104, 0));
        vecs.push_back(mk(0, 1, 2'b10, 11'h000, 11'h200, 11'h200, 0));
        vecs.push_back(mk(0, 1, 2'b11, 11'h000, 11'h000, 11'h200, 0));
        vecs.push_back(mk(0, 1, 2'b11, 11'h000, 11'h000, 11'h200, 0));
        vecs.push_back(mk(0, 0, 2'b01, 11'h040, 11'h000, 11'h200, 0));
        vecs.push_back(mk(0, 1, 2'b00, 11'h000, 11'h000, 11'h204, 0));
        vecs.push_back(mk(0, 1, 2'b10, 11'h000, 11'h7FC, 11'h7FC, 0));
        vecs.push_back(mk(0, 1, 2'b00, 11'h000, 11'h000, 11'h000, 0));
        vecs.push_back(mk(0, 1, 2'b10, 11'h000, 11'h203,
                          align_on ? 11'h200 : 11'h203, align_on));
        vecs.push_back(mk(0, 1, 2'b10, 11'h000, 11'h200, 11'h200, 0));
        vecs.push_back(mk(0, 1, 2'b00, 11'h000, 11'h000, 11'h204, 0));
        // Reset mid-operation wins over an active load.
        vecs.push_back(mk(1, 1, 2'b01, 11'h555, 11'h3FF, 11'h000, 0));
        vecs.push_back(mk(0, 1, 2'b00, 11'h000, 11'h000, 11'h004, 0));

        foreach (vecs[i])
            apply(vecs[i].rst, vecs[i].en, vecs[i].sel, vecs[i].imm, vecs[i].alu,
                  vecs[i].exp_pc, vecs[i].exp_mis, $sformatf("dir%0d", i));

        // Hand sequence: misaligned imm load, then a hold clears the flag.
        apply(0, 1, 2'b01, 11'h0A1, 11'h000, align_on ? 11'h0A0 : 11'h0A1, align_on, "seq_imm_mis");
        apply(0, 0, 2'b01, 11'h0A3, 11'h000, align_on ? 11'h0A0 : 11'h0A1, 0, "seq_mis_clear_en0");
        apply(0, 1, 2'b11, 11'h0A3, 11'h7F3, align_on ? 11'h0A0 : 11'h0A1, 0, "seq_mis_clear_hold");

        // Randomized run against an arithmetic reference model.
        model_pc = align_on ? 'h0A0 : 'h0A1;
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(15) == 0);
            e  = ($urandom_range(3) != 0);
            s  = 2'($urandom_range(3));
            im = ADDR_W'($urandom);
            al = ADDR_W'($urandom);
            mis = 1'b0;
            if (r) begin
                model_pc = 0;
            end else if (e && (s == 2'b01 || s == 2'b10)) begin
                tgt = (s == 2'b01) ? im : al;
                mis = align_on && (tgt % 4 != 0);
                model_pc = align_on ? (int'(tgt) / 4) * 4 : int'(tgt);
            end else if (e && s == 2'b00) begin
                model_pc = (model_pc + 4) & MASK;
            end
            apply(r, e, s, im, al, ADDR_W'(model_pc), mis, $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_block.md
Name: pc_block

Overview:
- Program counter register for the RISC-V core fetch stage.
- Holds the current instruction address. Each enabled cycle it selects the next address from one of four sources: sequential increment, immediate-computed branch/jump target, ALU-computed target (JALR), or hold.
- Output drives the instruction memory address directly.

Parameters:
- ADDR_W, 11, width of pc, imm_addr, alu_addr.
- RESET_VECTOR, 0, value loaded into pc on reset; must fit in ADDR_W bits.
- PC_INC, 4, sequential increment in bytes.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-high reset; asserted when 1, despite the _n suffix.
- pc_en  input  1  update enable; 0 = pc holds.
- pc_sel  input  2  next-pc source select.
- imm_addr  input  ADDR_W  branch/jump target computed from immediate.
- alu_addr  input  ADDR_W  jump target computed by ALU.
- pc  output  ADDR_W  current program counter, registered.

Behaviour:
- pc is a single ADDR_W-bit register; the output is taken directly from it, with no combinational path from inputs to pc.
- Reset: at a posedge with rst_n=1, pc <= RESET_VECTOR. Reset has priority over pc_en and pc_sel. While reset stays asserted, pc stays RESET_VECTOR.
- Reset mid-operation: takes effect at the next posedge regardless of other inputs. The first posedge after deassertion performs a normal update.
- When rst_n=0 and pc_en=1, pc_sel selects the next value at the posedge:
  - 00: pc <= pc + PC_INC.
  - 01: pc <= imm_addr.
  - 10: pc <= alu_addr.
  - 11: pc <= pc (reserved; hold).
- When rst_n=0 and pc_en=0: pc holds for any pc_sel, imm_addr or alu_addr.
- Latency: one cycle. Inputs sampled at posedge N appear on pc after posedge N.
- Arithmetic: pc + PC_INC is computed modulo 2^ADDR_W and wraps silently. Example: 0x7FC + 4 = 0x000. No overflow flag.
- imm_addr and alu_addr are loaded verbatim, with no alignment check, unless the optional feature is enabled.
- No X propagation on pc after the first reset; inputs are ignored when not selected.
- Initial (pre-reset) value of pc is undefined; the bench must apply reset first.

Optional Feature:
- Macro: PC_ALIGN_EN.
- Defined:
  - Loads from imm_addr/alu_addr (sel 01/10) write the target with bits [1:0] forced to 0.
  - Adds output port pc_misalign (1 bit, registered). It is 1 for exactly one cycle following a load whose selected target had nonzero bits [1:0]; otherwise 0.
  - pc_misalign resets to 0, and is 0 when pc_en=0 or pc_sel is 00/11.
- Not defined: targets are loaded unmodified and the pc_misalign port does not exist.

Test Plan:
- Reset: rst_n=1 for 2 cycles with pc_en=1, pc_sel=00 -> pc=0x000 after the first posedge and stays 0x000 while asserted. Repeat with pc_en=0 -> still 0x000.
- Sequential: release reset, pc_sel=00, pc_en=1 for 3 cycles -> pc = 0x004, 0x008, 0x00C on successive edges.
- Immediate jump: pc_sel=01, imm_addr=0x100 -> pc=0x100 one edge later. Then pc_sel=00 -> 0x104.
- ALU jump and hold:
  - pc_sel=10, alu_addr=0x200 -> pc=0x200.
  - pc_sel=11 for 2 cycles -> pc stays 0x200.
  - pc_en=0 with pc_sel=01, imm_addr=0x040 -> pc stays 0x200.
  - pc_en=1, pc_sel=00 -> 0x204.
- Wrap: load alu_addr=0x7FC via sel=10, then sel=00 -> pc=0x000.
- Alignment, loading alu_addr=0x203 via sel=10:
  - Without PC_ALIGN_EN -> pc=0x203.
  - With PC_ALIGN_EN -> pc=0x200 and pc_misalign=1 for one cycle; loading 0x200 instead -> pc_misalign=0.
